fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/STALL sequencer and the IF/ID pipeline register.
// Optional macro BRANCH_FLUSH_EN squashes the word fetched alongside a taken branch; otherwise it is a delay slot.
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        le_pc,
    input  logic        le_ifid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic        load_ifid;
    logic        flush_ifid;

    assign pc_plus4       = pc + 32'd4;
    assign target_aligned = branch_target & ~32'h3;
    assign imem_addr      = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc    <= 32'h0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // A stall freezes the PC and masks branch_taken; ID keeps the branch asserted until le_pc returns.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        load_ifid  = 1'b0;
        flush_ifid = 1'b0;
        case (state)
            BOOT: begin
                next_state = RUN;
                load_ifid  = 1'b1;
                flush_ifid = 1'b1;
            end
            RUN, STALL: begin
                load_ifid = le_ifid;
                if (le_pc) begin
                    next_state = RUN;
                    pc_next    = branch_taken ? target_aligned : pc_plus4;
`ifdef BRANCH_FLUSH_EN
                    flush_ifid = branch_taken;
`endif
                end else begin
                    next_state = STALL;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr    <= 32'h0;
            ifid_pc       <= 32'h0;
            ifid_pc_plus4 <= 32'd4;
            ifid_valid    <= 1'b0;
        end else if (load_ifid) begin
            ifid_instr    <= flush_ifid ? 32'h0 : imem_data;
            ifid_pc       <= pc;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= ~flush_ifid;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences for wrap and
// asynchronous reset, then randomized traffic against a behavioural fetch model.
module tb_fetch_stage;

`ifdef BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        le_pc;
    logic        le_ifid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] mem_xor = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic        m_valid;
    logic        m_boot;
    logic [31:0] pre_addr;

    typedef struct {
        logic        lp;
        logic        li;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    // Memory model: word depends only on the address, so the bench knows what any PC returns.
    assign imem_data = imem_addr ^ mem_xor;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .le_pc         (le_pc),
        .le_ifid       (le_ifid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_ifpc  = 32'h0;
        m_valid = 1'b0;
        m_boot  = 1'b1;
    endtask

    // One clock of the fetch stage described as architectural rules, not as a state machine.
    task automatic model_clock(input logic lp, input logic li, input logic br, input logic [31:0] tgt);
        logic [31:0] word;
        word = m_pc ^ mem_xor;
        if (m_boot) begin
            m_boot  = 1'b0;
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_ifpc  = m_pc;
        end else begin
            if (li) begin
                m_ifpc = m_pc;
                if (FLUSH && br && lp) begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                end else begin
                    m_instr = word;
                    m_valid = 1'b1;
                end
            end
            if (lp)
                m_pc = br ? (tgt / 4) * 4 : m_pc + 32'd4;
        end
    endtask

    task automatic checkOutput();
        check32("imem_addr", imem_addr, m_pc);
        check32("ifid_instr", ifid_instr, m_instr);
        check32("ifid_pc", ifid_pc, m_ifpc);
        check32("ifid_pc_plus4", ifid_pc_plus4, m_ifpc + 32'd4);
        check32("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    endtask

    // Called at a falling edge; returns at the next falling edge after one rising edge.
    task automatic applyStimulus(input logic lp, input logic li, input logic br, input logic [31:0] tgt);
        le_pc         = lp;
        le_ifid       = li;
        branch_taken  = br;
        branch_target = tgt;
        #1;
        pre_addr = imem_addr;
        check32("imem_addr_pre", imem_addr, m_pc);
        @(posedge clk);
        model_clock(lp, li, br, tgt);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,   32'h0,                 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,   32'h0,                 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h4,   32'h4,                 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   32'h4,                 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   32'h4,                 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   32'h4,                 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h8,   32'h8,                 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'hC,   32'hC,                 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h103, 32'h10,  FLUSH ? 32'h0 : 32'h10, !FLUSH};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h100, 32'h100,               1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h200, 32'h104, 32'h104,               1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h200, 32'h104, FLUSH ? 32'h0 : 32'h104, !FLUSH};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h200, 32'h200,               1'b1};

        reset         = 1'b1;
        le_pc         = 1'b1;
        le_ifid       = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput();
        reset = 1'b0;

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].lp, vecs[i].li, vecs[i].br, vecs[i].tgt);
            check32($sformatf("vec%0d_addr", i), pre_addr, vecs[i].exp_addr);
            check32($sformatf("vec%0d_instr", i), ifid_instr, vecs[i].exp_instr);
            check32($sformatf("vec%0d_valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].exp_valid});
        end

        $display("[TB] PC wrap at top of address space");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check32("wrap_addr_pre", pre_addr, 32'hFFFF_FFFC);
        check32("wrap_pc_plus4", ifid_pc_plus4, 32'h0);
        check32("wrap_addr_post", imem_addr, 32'h0);

        $display("[TB] asynchronous reset in the middle of a stall");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
        check32("stall_addr", imem_addr, 32'h40);
        #2 reset = 1'b1;
        #1;
        check32("arst_addr", imem_addr, 32'h0);
        check32("arst_instr", ifid_instr, 32'h0);
        check32("arst_pc", ifid_pc, 32'h0);
        check32("arst_pc_plus4", ifid_pc_plus4, 32'h4);
        check32("arst_valid", {31'h0, ifid_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check32("reboot_valid", {31'h0, ifid_valid}, 32'h0);

        $display("[TB] randomized traffic");
        mem_xor = $urandom;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) == 0, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
